// File: rtl/hex_scan_ctrl_pkg.sv
// rtl/hex_scan_ctrl_pkg.sv - shared constants, segment table and FSM states for hex_scan_ctrl
package hex_scan_ctrl_pkg;

   localparam int DIGITS = 8;

   localparam logic [6:0] BLANK = 7'h7F;

   // Active-low codes for nibble values 0..F, bit6=g .. bit0=a
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      COMMIT,
      HOLD
   } state_t;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational nibble to active-low 7-segment code
module seg7_decode
   import hex_scan_ctrl_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/hex_scan_ctrl.sv
// rtl/hex_scan_ctrl.sv - 8-digit hex display controller, one shared decoder scanned over digits
module hex_scan_ctrl
   import hex_scan_ctrl_pkg::*;
#(
   parameter int HOLD_CYCLES = 50000000,
   parameter bit BLANK_LZ    = 1'b1
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic [6:0]  hex0,
   output logic [6:0]  hex1,
   output logic [6:0]  hex2,
   output logic [6:0]  hex3,
   output logic [6:0]  hex4,
   output logic [6:0]  hex5,
   output logic [6:0]  hex6,
   output logic [6:0]  hex7,
   output logic        busy,
   output logic        done
);

   localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CW-1:0] HOLD_LAST = CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

   state_t          state;
   state_t          state_nx;
   logic [2:0]      idx;
   logic [31:0]     data;
   logic            lz;
   logic [CW-1:0]   hold_cnt;
   logic [6:0]      shadow [DIGITS];
   logic [6:0]      disp   [DIGITS];
   logic [3:0]      nib;
   logic [6:0]      seg;

   assign nib = data[{idx, 2'b00} +: 4];

   seg7_decode u_dec (
      .nibble (nib),
      .seg    (seg)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      busy     = 1'b0;
      case (state)
         IDLE: begin
            in_ready = !rst;
            if (in_valid) state_nx = CONV;
         end
         CONV: begin
            busy = !rst;
            if (idx == 3'd0) state_nx = COMMIT;
         end
         COMMIT: begin
            busy     = !rst;
            state_nx = (HOLD_CYCLES == 0) ? IDLE : HOLD;
         end
         HOLD: begin
            busy = !rst;
            if (hold_cnt == HOLD_LAST) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // lz stays set while every nibble scanned so far (from the top) was zero
   always_ff @(posedge clk) begin
      if (rst) begin
         idx      <= 3'd0;
         data     <= 32'd0;
         lz       <= 1'b0;
         hold_cnt <= '0;
         done     <= 1'b0;
         for (int i = 0; i < DIGITS; i++) begin
            shadow[i] <= BLANK;
            disp[i]   <= BLANK;
         end
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  data <= in_data;
                  idx  <= 3'd7;
                  lz   <= 1'b1;
               end
            end
            CONV: begin
               if (BLANK_LZ && lz && nib == 4'd0 && idx != 3'd0) shadow[idx] <= BLANK;
               else                                               shadow[idx] <= seg;
               if (nib != 4'd0) lz <= 1'b0;
               idx <= idx - 3'd1;
            end
            COMMIT: begin
               for (int i = 0; i < DIGITS; i++) disp[i] <= shadow[i];
               done     <= 1'b1;
               hold_cnt <= '0;
            end
            HOLD: begin
               hold_cnt <= (hold_cnt == HOLD_LAST) ? '0 : hold_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign hex0 = disp[0];
   assign hex1 = disp[1];
   assign hex2 = disp[2];
   assign hex3 = disp[3];
   assign hex4 = disp[4];
   assign hex5 = disp[5];
   assign hex6 = disp[6];
   assign hex7 = disp[7];

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// tb/tb_hex_scan_ctrl.sv - self-checking bench for hex_scan_ctrl, BLANK_LZ=1 and BLANK_LZ=0 instances
module tb_hex_scan_ctrl;

   localparam logic [6:0] TBL [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };
   localparam logic [55:0] ALL_BLANK = {8{7'h7F}};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = 32'd0;
   logic        rdy1, busy1, done1, rdy0, busy0, done0;
   logic [6:0]  a0, a1, a2, a3, a4, a5, a6, a7;
   logic [6:0]  b0, b1, b2, b3, b4, b5, b6, b7;
   logic [55:0] hv1, hv0;
   logic [5:0]  status;
   logic [55:0] shown1, shown0;
   int          errors = 0;
   int          checks = 0;

   assign hv1    = {a7, a6, a5, a4, a3, a2, a1, a0};
   assign hv0    = {b7, b6, b5, b4, b3, b2, b1, b0};
   assign status = {rdy1, busy1, done1, rdy0, busy0, done0};

   always #5 clk = ~clk;

   hex_scan_ctrl #(.HOLD_CYCLES(4), .BLANK_LZ(1'b1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
      .hex0(a0), .hex1(a1), .hex2(a2), .hex3(a3), .hex4(a4), .hex5(a5), .hex6(a6), .hex7(a7),
      .busy(busy1), .done(done1)
   );

   hex_scan_ctrl #(.HOLD_CYCLES(4), .BLANK_LZ(1'b0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
      .hex0(b0), .hex1(b1), .hex2(b2), .hex3(b3), .hex4(b4), .hex5(b5), .hex6(b6), .hex7(b7),
      .busy(busy0), .done(done0)
   );

   // Reference: digits above the highest nonzero nibble are blank when blanking is on
   function automatic logic [55:0] model(input logic [31:0] d, input bit blank);
      logic [55:0] r;
      logic [3:0]  n;
      int          top;
      top = 0;
      for (int i = 0; i < 8; i++)
         if (((d >> (4 * i)) & 32'hF) != 0) top = i;
      for (int i = 0; i < 8; i++) begin
         n = 4'((d >> (4 * i)) & 32'hF);
         r[i*7 +: 7] = (blank && i > top) ? 7'h7F : TBL[n];
      end
      return r;
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic xfer(input logic [31:0] d, input bit keep, input logic [31:0] nxt, input string name);
      logic [55:0] e1, e0;
      logic [5:0]  want;
      int          n;
      e1 = model(d, 1'b1);
      e0 = model(d, 1'b0);
      in_data  = d;
      in_valid = 1'b1;
      n = 0;
      while (!rdy1 && n < 50) begin
         step;
         n++;
      end
      checks++;
      if (rdy1 !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_timeout got %b want 1", name, rdy1);
         in_valid = 1'b0;
         return;
      end
      step;
      in_valid = keep;
      in_data  = keep ? nxt : $urandom;
      for (int k = 1; k <= 13; k++) begin
         if (k == 10) begin
            shown1 = e1;
            shown0 = e0;
         end
         want = (k == 10) ? 6'b011011 : 6'b010010;
         checks++;
         if (status !== want) begin
            errors++;
            $display("FAIL %s status T+%0d got %b want %b", name, k, status, want);
         end
         checks++;
         if (hv1 !== shown1 || hv0 !== shown0) begin
            errors++;
            $display("FAIL %s hex T+%0d got %h/%h want %h/%h", name, k, hv1, hv0, shown1, shown0);
         end
         step;
      end
      checks++;
      if (status !== 6'b100100) begin
         errors++;
         $display("FAIL %s status T+14 got %b want 100100", name, status);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      in_valid = 1'b0;
      repeat (3) step;
      checks++;
      if (hv1 !== ALL_BLANK || hv0 !== ALL_BLANK) begin
         errors++;
         $display("FAIL reset_hex got %h/%h want %h", hv1, hv0, ALL_BLANK);
      end
      checks++;
      if (status !== 6'b000000) begin
         errors++;
         $display("FAIL reset_status got %b want 000000", status);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (status !== 6'b100100) begin
         errors++;
         $display("FAIL reset_release got %b want 100100", status);
      end
      shown1 = ALL_BLANK;
      shown0 = ALL_BLANK;
   endtask

   task automatic test_1234abcd;
      logic [55:0] want;
      want = {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21};
      xfer(32'h1234ABCD, 1'b0, 32'd0, "x1234abcd");
      checks++;
      if (hv1 !== want || hv0 !== want) begin
         errors++;
         $display("FAIL x1234abcd_const got %h/%h want %h", hv1, hv0, want);
      end
   endtask

   task automatic test_lz_50;
      logic [55:0] w1, w0;
      w1 = {{6{7'h7F}}, 7'h12, 7'h40};
      w0 = {{6{7'h40}}, 7'h12, 7'h40};
      xfer(32'h00000050, 1'b0, 32'd0, "x50");
      checks++;
      if (hv1 !== w1 || hv0 !== w0) begin
         errors++;
         $display("FAIL x50_const got %h/%h want %h/%h", hv1, hv0, w1, w0);
      end
   endtask

   task automatic test_zero;
      logic [55:0] w1, w0;
      w1 = {{7{7'h7F}}, 7'h40};
      w0 = {8{7'h40}};
      xfer(32'h00000000, 1'b0, 32'd0, "zero");
      checks++;
      if (hv1 !== w1 || hv0 !== w0) begin
         errors++;
         $display("FAIL zero_const got %h/%h want %h/%h", hv1, hv0, w1, w0);
      end
   endtask

   task automatic test_random;
      logic [31:0] d;
      for (int i = 0; i < 10; i++) begin
         d = $urandom;
         d = d >> $urandom_range(0, 31);
         xfer(d, 1'b0, 32'd0, "random");
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] a, b;
      a = 32'h00C0FFEE;
      b = 32'h0000000B ^ ($urandom & 32'h0FF00000);
      xfer(a, 1'b1, b, "b2b_first");
      xfer(b, 1'b0, 32'd0, "b2b_second");
   endtask

   task automatic test_abort;
      in_data  = 32'hFFFFFFFF;
      in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      repeat (4) step;
      rst = 1'b1;
      step;
      checks++;
      if (hv1 !== ALL_BLANK || hv0 !== ALL_BLANK || status !== 6'b000000) begin
         errors++;
         $display("FAIL abort_in_reset got %h/%h %b want %h 000000", hv1, hv0, status, ALL_BLANK);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (status !== 6'b100100) begin
         errors++;
         $display("FAIL abort_release got %b want 100100", status);
      end
      for (int k = 0; k < 15; k++) begin
         step;
         checks++;
         if (done1 !== 1'b0 || done0 !== 1'b0 || hv1 !== ALL_BLANK || hv0 !== ALL_BLANK) begin
            errors++;
            $display("FAIL abort_after cyc %0d got done %b%b hex %h/%h want 00 %h", k, done1, done0, hv1, hv0, ALL_BLANK);
         end
      end
      shown1 = ALL_BLANK;
      shown0 = ALL_BLANK;
   endtask

   initial begin
      test_reset;
      test_1234abcd;
      test_lz_50;
      test_zero;
      test_random;
      test_back_to_back;
      test_abort;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
